// File: rtl/stream_to_block_packer.sv
// Packs a stream of elements into sorter-sized blocks, padding short frames.
// Optional split-frame counter port err_cnt: define STREAM_PACKER_ERRCNT_EN.
module stream_to_block_packer #(
    parameter int                    NUM_ELEMS  = 16,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b1}}
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             src_tvalid,
    output logic                             src_tready,
    input  logic [DATA_WIDTH-1:0]            src_tdata,
    input  logic                             src_tlast,
    output logic                             dest_tvalid,
    input  logic                             dest_tready,
    output logic [DATA_WIDTH*NUM_ELEMS-1:0]  dest_tdata_raw,
    output logic [$clog2(NUM_ELEMS+1)-1:0]   dest_count,
    output logic                             dest_last
`ifdef STREAM_PACKER_ERRCNT_EN
    ,
    output logic [15:0]                      err_cnt
`endif
);

    localparam int IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam int CNT_W = $clog2(NUM_ELEMS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_slot [NUM_ELEMS];
    logic [CNT_W-1:0]      r_count;
    logic                  r_last;

    logic w_accept;
    logic w_at_end;
    logic w_close;

    assign src_tready  = (r_state == FILL) && !rst;
    assign dest_tvalid = (r_state == HOLD) && !rst;

    assign w_accept = src_tvalid && src_tready;
    assign w_at_end = (r_idx == LAST_IDX);
    assign w_close  = w_accept && (w_at_end || src_tlast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FILL;
            r_idx   <= '0;
            r_count <= '0;
            r_last  <= 1'b0;
        end else begin
            unique case (r_state)
                FILL: begin
                    if (w_close) begin
                        r_state <= HOLD;
                        r_count <= CNT_W'(r_idx) + CNT_W'(1);
                        r_last  <= src_tlast;
                        r_idx   <= '0;
                    end else if (w_accept) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                HOLD: begin
                    if (dest_tready) begin
                        r_state <= FILL;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    // Slots above the closing index are padded so short frames sort high.
    for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot[k] <= '0;
            end else if (w_accept) begin
                if (r_idx == IDX_W'(k)) begin
                    r_slot[k] <= src_tdata;
                end else if (w_close && (k > int'(r_idx))) begin
                    r_slot[k] <= PAD_VALUE;
                end
            end
        end
        assign dest_tdata_raw[k*DATA_WIDTH +: DATA_WIDTH] = r_slot[k];
    end

    assign dest_count = r_count;
    assign dest_last  = r_last;

`ifdef STREAM_PACKER_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_split;

    assign w_split = w_accept && w_at_end && !src_tlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_split && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: doc/stream_to_block_packer.md
Name: stream_to_block_packer

Overview:
- Upstream feeder for the parallel sorter.
- Accepts one DATA_WIDTH element per AXI-Stream-style beat and accumulates NUM_ELEMS elements into one wide block.
- Presents the block on a valid/ready interface whose data layout matches the sorter input (element k at bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]).
- Short frames (early src_tlast) are padded so that padding sorts to the top slots.

Parameters:
- NUM_ELEMS, 16, elements per block; legal range ≥1.
- DATA_WIDTH, 8, bits per element.
- PAD_VALUE, {DATA_WIDTH{1'b1}}, value written into unfilled slots on a short frame.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- src_tvalid  in  1  element beat valid.
- src_tready  out  1  packer accepts beat.
- src_tdata  in  DATA_WIDTH  element.
- src_tlast  in  1  last element of frame.
- dest_tvalid  out  1  block valid.
- dest_tready  in  1  sorter accepts block.
- dest_tdata_raw  out  DATA_WIDTH*NUM_ELEMS  packed block; slot 0 holds the first-received element.
- dest_count  out  $clog2(NUM_ELEMS+1)  number of real (non-pad) elements in block, 1..NUM_ELEMS.
- dest_last  out  1  block ended by src_tlast.
- err_cnt  out  16  present only with STREAM_PACKER_ERRCNT_EN; see Optional Feature.

Behaviour:
- Registers: state (FILL, HOLD), slot index idx (0..NUM_ELEMS-1), block register, count register, last register.
- Reset (rst high at posedge): state=FILL, idx=0, block=0, dest_count=0, dest_last=0, err_cnt=0. Combinationally while rst=1: dest_tvalid=0, src_tready=0. Reset overrides all other updates. A partially filled block is discarded.
- src_tready = (state==FILL) && !rst. dest_tvalid = (state==HOLD) && !rst. Both are purely state-derived; no combinational path from dest_tready to src_tready.
- FILL, beat accepted (src_tvalid && src_tready):
  - slot[idx] <= src_tdata.
  - If idx==NUM_ELEMS-1 or src_tlast: go to HOLD; dest_count <= idx+1; dest_last <= src_tlast; every slot > idx <= PAD_VALUE; idx <= 0.
  - Otherwise idx <= idx+1.
- FILL, no beat: all registers hold.
- HOLD: block, dest_count and dest_last are stable while dest_tvalid=1 && !dest_tready. On dest_tvalid && dest_tready, go to FILL in the next cycle. Stale slot contents are don't-care because they are overwritten or padded before the next HOLD.
- Latency: dest_tvalid rises the cycle after the final beat is accepted. Minimum block period is NUM_ELEMS+1 cycles (one bubble for the HOLD handshake).
- Overlong frame: a full block with no tlast on the final beat is emitted with dest_last=0 and dest_count=NUM_ELEMS. Subsequent beats start a new block at slot 0.
- Boundary cases:
  - tlast on the first beat gives dest_count=1 and slots 1..N-1 = PAD_VALUE.
  - tlast exactly on slot NUM_ELEMS-1 gives no padding and dest_last=1.
  - NUM_ELEMS=1: every accepted beat goes directly to HOLD.
- src_tdata and src_tlast are ignored when no handshake occurs.

Optional Feature:
- Macro: STREAM_PACKER_ERRCNT_EN.
- Defined: adds port err_cnt (16 bits, reset 0). err_cnt increments by 1 each time a block is completed at idx==NUM_ELEMS-1 without src_tlast (frame split). It saturates at 16'hFFFF.
- Undefined: port err_cnt and its logic are absent. Data behaviour is identical in both cases.

Test Plan (NUM_ELEMS=4, DATA_WIDTH=8):
1. Full frame: beats 0x33,0x11,0x44,0x22 with tlast on the 4th, dest_tready=1 → next cycle dest_tvalid=1, dest_tdata_raw=32'h22441133, dest_count=4, dest_last=1. One cycle later src_tready=1.
2. Short frame: beats 0x05,0x07 with tlast on the 2nd → dest_tdata_raw=32'hFFFF0705, dest_count=2, dest_last=1.
3. Backpressure: complete block with dest_tready=0 for 5 cycles → dest_tvalid and data stable, src_tready=0 throughout. Raising dest_tready gives a handshake and FILL on the following cycle.
4. Overlong frame: 6 beats 0x01..0x06 with tlast on the 6th → block 1 = 32'h04030201, count 4, last 0. Block 2 = 32'hFFFF0605, count 2, last 1. With the macro, err_cnt=1.
5. Reset mid-fill: 2 beats accepted, rst pulsed for 1 cycle, then 4 beats 0xA0..0xA3 with tlast → block = 32'hA3A2A1A0 (pre-reset beats gone). dest_tvalid=0 and src_tready=0 during rst.
6. Bubbly source: src_tvalid toggled randomly over 4 beats → block contents and order match scenario 1 regardless of gaps.
